// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module   : vga_timing_pkg
// Brief    : Shared raster-timing types and 720p default constants.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int unsigned c_CNT_W   = 12;
    localparam int unsigned c_CNT_MAX = 4095;
    localparam int unsigned c_FC_W    = 16;

    // CEA 1280x720@60, 74.25 MHz pixel clock
    localparam int unsigned c_720P_H_ACTIVE = 1280;
    localparam int unsigned c_720P_H_FRONT  = 110;
    localparam int unsigned c_720P_H_SYNC   = 40;
    localparam int unsigned c_720P_H_BACK   = 220;
    localparam int unsigned c_720P_V_ACTIVE = 720;
    localparam int unsigned c_720P_V_FRONT  = 5;
    localparam int unsigned c_720P_V_SYNC   = 5;
    localparam int unsigned c_720P_V_BACK   = 20;
    localparam int unsigned c_720P_SYNC_HI  = 1;

    typedef enum logic [1:0] {
        H_ACTIVE = 2'd0,
        H_FRONT  = 2'd1,
        H_SYNC   = 2'd2,
        H_BACK   = 2'd3
    } h_state_t;

    typedef enum logic [1:0] {
        V_ACTIVE = 2'd0,
        V_FRONT  = 2'd1,
        V_SYNC   = 2'd2,
        V_BACK   = 2'd3
    } v_state_t;

    // Axis-neutral encoding shared by both counter instances; matches h/v_state_t.
    typedef enum logic [1:0] {
        AX_ACTIVE = 2'd0,
        AX_FRONT  = 2'd1,
        AX_SYNC   = 2'd2,
        AX_BACK   = 2'd3
    } axis_state_t;

    function automatic int unsigned axis_total(
        input int unsigned active,
        input int unsigned front,
        input int unsigned sync,
        input int unsigned back
    );
        return active + front + sync + back;
    endfunction

    localparam int unsigned c_720P_H_TOTAL =
        axis_total(c_720P_H_ACTIVE, c_720P_H_FRONT, c_720P_H_SYNC, c_720P_H_BACK);
    localparam int unsigned c_720P_V_TOTAL =
        axis_total(c_720P_V_ACTIVE, c_720P_V_FRONT, c_720P_V_SYNC, c_720P_V_BACK);

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// ============================================================================
// Module   : vga_axis_counter
// Brief    : One raster axis: wrapping position counter with its
//            active/front/sync/back FSM and registered sync flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE_COUNT     = 1280,
    parameter int unsigned FRONT_PORCH      = 110,
    parameter int unsigned SYNC_WIDTH       = 40,
    parameter int unsigned BACK_PORCH       = 220,
    parameter int unsigned SYNC_ACTIVE_HIGH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step,
    input  logic               start,
    output logic [c_CNT_W-1:0] count,
    output axis_state_t        state_next,
    output logic               wrap,
    output logic               sync
);

    localparam int unsigned c_TOTAL =
        axis_total(ACTIVE_COUNT, FRONT_PORCH, SYNC_WIDTH, BACK_PORCH);

    if (c_TOTAL > c_CNT_MAX) begin : g_total_check
        $error("vga_axis_counter: axis total exceeds 4095");
    end

    if ((ACTIVE_COUNT == 0) || (FRONT_PORCH == 0) ||
        (SYNC_WIDTH == 0) || (BACK_PORCH == 0)) begin : g_segment_check
        $error("vga_axis_counter: every timing segment must be at least 1");
    end

    // Last count of each segment; the FSM leaves a segment on the step out of it.
    localparam logic [c_CNT_W-1:0] c_ACTIVE_LAST = c_CNT_W'(ACTIVE_COUNT - 1);
    localparam logic [c_CNT_W-1:0] c_FRONT_LAST  = c_CNT_W'(ACTIVE_COUNT + FRONT_PORCH - 1);
    localparam logic [c_CNT_W-1:0] c_SYNC_LAST   =
        c_CNT_W'(ACTIVE_COUNT + FRONT_PORCH + SYNC_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_TOTAL_LAST  = c_CNT_W'(c_TOTAL - 1);

    localparam logic c_SYNC_ASSERT = (SYNC_ACTIVE_HIGH != 0) ? 1'b1 : 1'b0;
    localparam logic c_SYNC_IDLE   = ~c_SYNC_ASSERT;

    logic [c_CNT_W-1:0] r_count;
    axis_state_t        r_state;
    axis_state_t        w_state_next;
    logic               w_wrap;
    logic               r_sync;

    assign w_wrap = step && (r_count == c_TOTAL_LAST);

    always_comb begin
        w_state_next = r_state;
        if (step) begin
            case (r_state)
                AX_ACTIVE: if (r_count == c_ACTIVE_LAST) w_state_next = AX_FRONT;
                AX_FRONT:  if (r_count == c_FRONT_LAST)  w_state_next = AX_SYNC;
                AX_SYNC:   if (r_count == c_SYNC_LAST)   w_state_next = AX_BACK;
                AX_BACK:   if (r_count == c_TOTAL_LAST)  w_state_next = AX_ACTIVE;
                default:   w_state_next = AX_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= AX_ACTIVE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Sync is registered from the next state so it lines up with the new count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_sync  <= c_SYNC_IDLE;
        end else begin
            if (step) begin
                r_count <= w_wrap ? '0 : r_count + 1'b1;
            end
            if (step || start) begin
                r_sync <= (w_state_next == AX_SYNC) ? c_SYNC_ASSERT : c_SYNC_IDLE;
            end
        end
    end

    assign count      = r_count;
    assign state_next = w_state_next;
    assign wrap       = w_wrap;
    assign sync       = r_sync;

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module   : vga_timing_gen
// Brief    : VGA raster timing: h/v counters, syncs, display enable and
//            line/frame markers. VGA_TIMING_FRAME_COUNT_EN adds frame_count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE_PIXEL_COUNT = c_720P_H_ACTIVE,
    parameter int unsigned H_FRONT_PORCH        = c_720P_H_FRONT,
    parameter int unsigned H_SYNC_WIDTH         = c_720P_H_SYNC,
    parameter int unsigned H_BACK_PORCH         = c_720P_H_BACK,
    parameter int unsigned V_ACTIVE_LINE_COUNT  = c_720P_V_ACTIVE,
    parameter int unsigned V_FRONT_PORCH        = c_720P_V_FRONT,
    parameter int unsigned V_SYNC_WIDTH         = c_720P_V_SYNC,
    parameter int unsigned V_BACK_PORCH         = c_720P_V_BACK,
    parameter int unsigned SYNC_ACTIVE_HIGH     = c_720P_SYNC_HI
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_ce,
    output logic [c_CNT_W-1:0] h_counter,
    output logic [c_CNT_W-1:0] v_counter,
    output logic               h_sync,
    output logic               v_sync,
    output logic               disp_en,
    output logic               line_start,
    output logic               frame_start
`ifdef VGA_TIMING_FRAME_COUNT_EN
    ,
    output logic [c_FC_W-1:0]  frame_count
`endif
);

    logic        r_running;
    logic        w_start;
    logic        w_h_step;
    logic        w_h_wrap;
    logic        w_v_wrap;
    logic        w_frame_wrap;
    axis_state_t w_h_axis_next;
    axis_state_t w_v_axis_next;
    h_state_t    w_h_state_next;
    v_state_t    w_v_state_next;
    logic        r_disp_en;
    logic        r_line_start;
    logic        r_frame_start;

    // The first enabled cycle after reset presents (0,0) without advancing.
    assign w_start      = pix_ce && !r_running;
    assign w_h_step     = pix_ce && r_running;
    assign w_frame_wrap = w_h_wrap && w_v_wrap;

    vga_axis_counter #(
        .ACTIVE_COUNT     (H_ACTIVE_PIXEL_COUNT),
        .FRONT_PORCH      (H_FRONT_PORCH),
        .SYNC_WIDTH       (H_SYNC_WIDTH),
        .BACK_PORCH       (H_BACK_PORCH),
        .SYNC_ACTIVE_HIGH (SYNC_ACTIVE_HIGH)
    ) u_h_axis (
        .clk        (clk),
        .rst        (rst),
        .step       (w_h_step),
        .start      (w_start),
        .count      (h_counter),
        .state_next (w_h_axis_next),
        .wrap       (w_h_wrap),
        .sync       (h_sync)
    );

    vga_axis_counter #(
        .ACTIVE_COUNT     (V_ACTIVE_LINE_COUNT),
        .FRONT_PORCH      (V_FRONT_PORCH),
        .SYNC_WIDTH       (V_SYNC_WIDTH),
        .BACK_PORCH       (V_BACK_PORCH),
        .SYNC_ACTIVE_HIGH (SYNC_ACTIVE_HIGH)
    ) u_v_axis (
        .clk        (clk),
        .rst        (rst),
        .step       (w_h_wrap),
        .start      (w_start),
        .count      (v_counter),
        .state_next (w_v_axis_next),
        .wrap       (w_v_wrap),
        .sync       (v_sync)
    );

    assign w_h_state_next = h_state_t'(w_h_axis_next);
    assign w_v_state_next = v_state_t'(w_v_axis_next);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_running     <= 1'b0;
            r_disp_en     <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            if (w_start) begin
                r_running <= 1'b1;
            end
            if (pix_ce) begin
                r_disp_en <= (w_h_state_next == H_ACTIVE) && (w_v_state_next == V_ACTIVE);
            end
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_frame_wrap;
        end
    end

    assign disp_en     = r_disp_en;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [c_FC_W-1:0] r_frame_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_count <= '0;
        end else if (w_frame_wrap) begin
            r_frame_count <= r_frame_count + 1'b1;
        end
    end

    assign frame_count = r_frame_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Directed self-checking bench: 720p instance plus two reduced
//            raster instances (sync active high / active low).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

    localparam int SH_A = 16, SH_F = 4, SH_S = 3, SH_B = 5;   // 28 pixels/line
    localparam int SV_A = 6,  SV_F = 2, SV_S = 2, SV_B = 3;   // 13 lines/frame
    localparam int S_FRAME = 28 * 13;

    typedef struct {
        bit run;
        int h;
        int v;
        bit hs;
        bit vs;
        bit de;
        bit ls;
        bit fs;
        int fc;
    } model_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pix_ce = 1'b0;

    logic [11:0] h_d, v_d, h_s, v_s, h_n, v_n;
    logic hs_d, vs_d, de_d, ls_d, fs_d;
    logic hs_s, vs_s, de_s, ls_s, fs_s;
    logic hs_n, vs_n, de_n, ls_n, fs_n;
`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [15:0] fc_d, fc_s, fc_n;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    model_t md, ms;

    always #5 clk = ~clk;

    vga_timing_gen dut_def (
        .clk(clk), .rst(rst), .pix_ce(pix_ce),
        .h_counter(h_d), .v_counter(v_d), .h_sync(hs_d), .v_sync(vs_d),
        .disp_en(de_d), .line_start(ls_d), .frame_start(fs_d)
`ifdef VGA_TIMING_FRAME_COUNT_EN
        , .frame_count(fc_d)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE_PIXEL_COUNT(SH_A), .H_FRONT_PORCH(SH_F), .H_SYNC_WIDTH(SH_S), .H_BACK_PORCH(SH_B),
        .V_ACTIVE_LINE_COUNT(SV_A), .V_FRONT_PORCH(SV_F), .V_SYNC_WIDTH(SV_S), .V_BACK_PORCH(SV_B),
        .SYNC_ACTIVE_HIGH(1)
    ) dut_s (
        .clk(clk), .rst(rst), .pix_ce(pix_ce),
        .h_counter(h_s), .v_counter(v_s), .h_sync(hs_s), .v_sync(vs_s),
        .disp_en(de_s), .line_start(ls_s), .frame_start(fs_s)
`ifdef VGA_TIMING_FRAME_COUNT_EN
        , .frame_count(fc_s)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE_PIXEL_COUNT(SH_A), .H_FRONT_PORCH(SH_F), .H_SYNC_WIDTH(SH_S), .H_BACK_PORCH(SH_B),
        .V_ACTIVE_LINE_COUNT(SV_A), .V_FRONT_PORCH(SV_F), .V_SYNC_WIDTH(SV_S), .V_BACK_PORCH(SV_B),
        .SYNC_ACTIVE_HIGH(0)
    ) dut_n (
        .clk(clk), .rst(rst), .pix_ce(pix_ce),
        .h_counter(h_n), .v_counter(v_n), .h_sync(hs_n), .v_sync(vs_n),
        .disp_en(de_n), .line_start(ls_n), .frame_start(fs_n)
`ifdef VGA_TIMING_FRAME_COUNT_EN
        , .frame_count(fc_n)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic model_t model_reset();
        model_t m;
        m.run = 0; m.h = 0; m.v = 0; m.hs = 0; m.vs = 0;
        m.de = 0; m.ls = 0; m.fs = 0; m.fc = 0;
        return m;
    endfunction

    // Behavioural raster: position advances, flags are decoded from position.
    function automatic model_t model_next(model_t m, bit rst_n, bit ce,
                                          int ha, int hf, int hsw, int hb,
                                          int va, int vf, int vsw, int vb);
        model_t n = m;
        int ht = ha + hf + hsw + hb;
        int vt = va + vf + vsw + vb;
        if (!rst_n) return model_reset();
        n.ls = 0;
        n.fs = 0;
        if (ce) begin
            if (!m.run) begin
                n.run = 1;
            end else if (m.h == ht - 1) begin
                n.h  = 0;
                n.ls = 1;
                if (m.v == vt - 1) begin
                    n.v  = 0;
                    n.fs = 1;
                    n.fc = (m.fc + 1) % 65536;
                end else begin
                    n.v = m.v + 1;
                end
            end else begin
                n.h = m.h + 1;
            end
            n.hs = (n.h >= ha + hf) && (n.h < ha + hf + hsw);
            n.vs = (n.v >= va + vf) && (n.v < va + vf + vsw);
            n.de = (n.h < ha) && (n.v < va);
        end
        return n;
    endfunction

    task automatic compare_all();
        chk("def_state", {h_d, v_d, hs_d, vs_d, de_d, ls_d, fs_d},
            {12'(md.h), 12'(md.v), md.hs, md.vs, md.de, md.ls, md.fs});
        chk("hi_state", {h_s, v_s, hs_s, vs_s, de_s, ls_s, fs_s},
            {12'(ms.h), 12'(ms.v), ms.hs, ms.vs, ms.de, ms.ls, ms.fs});
        chk("lo_state", {h_n, v_n, ~hs_n, ~vs_n, de_n, ls_n, fs_n},
            {12'(ms.h), 12'(ms.v), ms.hs, ms.vs, ms.de, ms.ls, ms.fs});
`ifdef VGA_TIMING_FRAME_COUNT_EN
        chk("def_fcount", fc_d, 16'(md.fc));
        chk("lo_fcount", fc_n, 16'(ms.fc));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        md = model_next(md, rst, pix_ce, 1280, 110, 40, 220, 720, 5, 5, 20);
        ms = model_next(ms, rst, pix_ce, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B);
        #1;
        compare_all();
    endtask

    initial begin
        int hs_cnt, hs_first, ls_cnt, fs_cnt, de_cnt, prev, gap, quiet_bad;
        bit found;
        md = model_reset();
        ms = model_reset();

        // Reset state
        repeat (3) tick();
        chk("rst_h", h_d, 0);
        chk("rst_de", de_d, 0);
        chk("rst_hs_lo_pol", hs_n, 1);
        chk("rst_vs_hi_pol", vs_s, 0);

        // Release with pix_ce high: first cycle presents (0,0)
        rst = 1'b1;
        pix_ce = 1'b1;
        tick();
        chk("arm_h", h_d, 0);
        chk("arm_de", de_d, 1);
        chk("arm_ls", ls_d, 0);
        chk("arm_fs", fs_s, 0);

        hs_cnt = 0; hs_first = -1; ls_cnt = 0; fs_cnt = 0; de_cnt = 0;
        for (int i = 1; i <= 1650; i++) begin
            tick();
            if (hs_d) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(h_d);
            end
            if (ls_d) ls_cnt++;
            if (fs_s) fs_cnt++;
            if (i <= S_FRAME && de_s) de_cnt++;
        end
        chk("line_h", h_d, 0);
        chk("line_v", v_d, 1);
        chk("line_ls", ls_d, 1);
        chk("def_hs_width", hs_cnt, 40);
        chk("def_hs_first", hs_first, 1390);
        chk("def_ls_count", ls_cnt, 1);
        chk("hi_pos_1650", {h_s, v_s}, {12'd26, 12'd6});
        chk("hi_fs_count", fs_cnt, 4);
        chk("hi_de_per_frame", de_cnt, 96);

        // pix_ce toggling: line spacing doubles, no pulses while disabled
        prev = -1; gap = -1; quiet_bad = 0;
        for (int i = 0; i < 800; i++) begin
            pix_ce = (i % 2 == 0);
            tick();
            if (!pix_ce && (ls_s || fs_s || ls_d || fs_d || ls_n || fs_n)) quiet_bad++;
            if (ls_s) begin
                if (prev >= 0) gap = i - prev;
                prev = i;
            end
        end
        chk("tog_line_gap", gap, 56);
        chk("tog_quiet", quiet_bad, 0);

        // Seek a mid-raster position, then reset asynchronously
        pix_ce = 1'b1;
        found = 0;
        for (int k = 0; k < 1000 && !found; k++) begin
            tick();
            found = (h_s == 12'd10) && (v_s == 12'd4);
        end
        chk("seek_mid", found, 1);
        rst = 1'b0;
        #1;
        md = model_reset();
        ms = model_reset();
        compare_all();
        chk("arst_pos", {h_s, v_s}, 0);
        chk("arst_de", de_s, 0);
        chk("arst_hs_lo_pol", hs_n, 1);
        repeat (2) tick();

        // Release with pix_ce low: nothing moves until pix_ce returns
        rst = 1'b1;
        pix_ce = 1'b0;
        repeat (2) tick();
        chk("hold_h", h_s, 0);
        chk("hold_de", de_s, 0);
        pix_ce = 1'b1;
        tick();
        chk("rearm_de", de_s, 1);
        repeat (3 * S_FRAME) tick();
        chk("f3_pos", {h_s, v_s}, 0);
        chk("f3_fs", fs_s, 1);
`ifdef VGA_TIMING_FRAME_COUNT_EN
        chk("f3_fcount", fc_n, 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
